i2c_target_responder: RTL and testbench



---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_target_responder.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared I2C state encoding, R/W bit values and default address
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_BYTE   = 3'd3,
        RX_ACK    = 3'd4,
        TX_BYTE   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic       I2C_RW_WRITE     = 1'b0;
    localparam logic       I2C_RW_READ      = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2A;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// i2c_bus_sync : SCL/SDA synchronizer with edge, START and STOP detection
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2    // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_s,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_s;

    // Preset to 1 so an idle (pulled-up) bus produces no edges out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
    assign o_sda_s     = w_sda_s;
    assign o_scl_rise  = w_scl_s & ~r_scl_d;
    assign o_scl_fall  = ~w_scl_s & r_scl_d;
    assign o_start_det = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign o_stop_det  = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

endmodule

`default_nettype wire

// File: rtl/i2c_target_responder.sv
// ============================================================================
// i2c_target_responder : 7-bit addressed I2C target with byte rx/tx interface
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy,
    output logic       addr_match
);

    logic w_sda_s, w_scl_rise, w_scl_fall, w_start_det, w_stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_scl       (i2c_scl),
        .i_sda       (i2c_sda),
        .o_sda_s     (w_sda_s),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det)
    );

    i2c_state_t r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [7:0] r_shift, w_shift;
    logic [7:0] w_shift_in;
    logic       r_rw, w_rw;
    logic       r_sda_oe, w_sda_oe;
    logic       r_tx_pend, w_tx_pend;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_pend, w_rx_pend;
    logic       r_rx_valid;
    logic       r_addr_match, w_match;
    logic       r_busy, w_busy;
    logic       w_tx_load;

    assign w_shift_in = {r_shift[6:0], w_sda_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd7;
            r_shift      <= 8'h00;
            r_rw         <= I2C_RW_WRITE;
            r_sda_oe     <= 1'b0;
            r_tx_pend    <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_pend    <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit_cnt    <= w_bit_cnt;
            r_shift      <= w_shift;
            r_rw         <= w_rw;
            r_sda_oe     <= w_sda_oe;
            r_tx_pend    <= w_tx_pend;
            r_rx_data    <= w_rx_data;
            r_rx_pend    <= w_rx_pend;
            r_rx_valid   <= r_rx_pend;
            r_addr_match <= w_match;
            r_busy       <= w_busy;
        end
    end

    // In the ACK states, r_sda_oe doubles as the phase marker: the first
    // scl_fall asserts the ACK, the second one releases it and moves on.
    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_rw      = r_rw;
        w_sda_oe  = r_sda_oe;
        w_tx_pend = r_tx_pend;
        w_rx_data = r_rx_data;
        w_rx_pend = 1'b0;
        w_match   = 1'b0;
        w_busy    = r_busy;
        w_tx_load = 1'b0;

        if (w_stop_det) begin
            w_state  = IDLE;
            w_sda_oe = 1'b0;
            w_busy   = 1'b0;
        end else if (w_start_det) begin
            w_state   = ADDR;
            w_bit_cnt = 3'd7;
            w_sda_oe  = 1'b0;
        end else begin
            case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift = w_shift_in;
                    if (r_bit_cnt == 3'd0) begin
                        w_rw = w_sda_s;
                        if (r_shift[6:0] == TARGET_ADDR) begin
                            w_state = ADDR_ACK;
                            w_match = 1'b1;
                            w_busy  = 1'b1;
                        end else begin
                            w_state = IDLE;
                            w_busy  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt - 3'd1;
                    end
                end
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe = 1'b1;
                    end else if (r_rw == I2C_RW_READ) begin
                        w_state   = TX_BYTE;
                        w_tx_load = 1'b1;
                        w_shift   = tx_data;
                        w_sda_oe  = ~tx_data[7];
                        w_bit_cnt = 3'd7;
                        w_tx_pend = 1'b0;
                    end else begin
                        w_state   = RX_BYTE;
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = 3'd7;
                    end
                end
                RX_BYTE: if (w_scl_rise) begin
                    w_shift = w_shift_in;
                    if (r_bit_cnt == 3'd0) begin
                        w_rx_data = w_shift_in;
                        w_rx_pend = 1'b1;
                        w_state   = RX_ACK;
                    end else begin
                        w_bit_cnt = r_bit_cnt - 3'd1;
                    end
                end
                RX_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe = 1'b1;
                    end else begin
                        w_sda_oe  = 1'b0;
                        w_state   = RX_BYTE;
                        w_bit_cnt = 3'd7;
                    end
                end
                TX_BYTE: if (w_scl_fall) begin
                    if (r_tx_pend) begin
                        w_sda_oe  = ~r_shift[7];
                        w_tx_pend = 1'b0;
                    end else if (r_bit_cnt == 3'd0) begin
                        w_sda_oe = 1'b0;
                        w_state  = TX_ACK;
                    end else begin
                        w_shift   = {r_shift[6:0], 1'b0};
                        w_sda_oe  = ~r_shift[6];
                        w_bit_cnt = r_bit_cnt - 3'd1;
                    end
                end
                TX_ACK: if (w_scl_rise) begin
                    if (!w_sda_s) begin
                        w_tx_load = 1'b1;
                        w_shift   = tx_data;
                        w_bit_cnt = 3'd7;
                        w_tx_pend = 1'b1;
                        w_state   = TX_BYTE;
                    end else begin
                        w_sda_oe = 1'b0;
                        w_state  = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda    = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_load    = w_tx_load & ~rst;
    assign busy       = r_busy;
    assign addr_match = r_addr_match;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
// ============================================================================
// tb_i2c_target_responder : bus-level master model with rx_valid scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_target_responder;
    import i2c_pkg::*;

    localparam int Q = 5;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, busy, addr_match;
    wire        sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target_responder #(
        .TARGET_ADDR (7'h2A),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (m_scl),
        .i2c_sda    (sda_bus),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .busy       (busy),
        .addr_match (addr_match)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_am = 0, n_txl = 0, n_rxv = 0, n_tgt_low = 0;
    logic [7:0] q_rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected rx bytes on each rx_valid, tallies pulses
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                n_rxv++;
                if (q_rx.size() == 0) begin
                    check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = q_rx.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e});
                end
            end
            if (addr_match) n_am++;
            if (tx_load) n_txl++;
            if ((rx_valid && tx_load) || (addr_match && (rx_valid || tx_load)))
                check("pulse_overlap", 32'd1, 32'd0);
            if (sda_bus === 1'b0 && !m_sda_low) n_tgt_low++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic obs);
        wclk(Q); m_sda_low = ~b;
        wclk(Q); m_scl = 1'b1;
        wclk(Q); obs = sda_bus;
        wclk(Q); m_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wclk(Q); m_sda_low = 1'b0;
        wclk(Q); m_scl = 1'b1;
        wclk(Q); b = sda_bus;
        wclk(Q); m_scl = 1'b0;
    endtask

    task automatic start_cond();
        if (m_scl == 1'b0) begin
            wclk(Q); m_sda_low = 1'b0;
            wclk(Q); m_scl = 1'b1;
            wclk(H);
        end
        m_sda_low = 1'b1;
        wclk(H); m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        wclk(Q); m_sda_low = 1'b1;
        wclk(Q); m_scl = 1'b1;
        wclk(H); m_sda_low = 1'b0;
        wclk(H);
    endtask

    task automatic write_bits(input logic [7:0] d, input int nbits);
        logic o;
        for (int i = 7; i > 7 - nbits; i--) send_bit(d[i], o);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        write_bits(d, 8);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic m_ack, output logic obs);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~m_ack, obs);
    endtask

    initial begin
        logic       ack, obs;
        logic [7:0] d;
        int         am0, tx0, rv0, tl0;

        wclk(5);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        rst = 1'b0;
        wclk(5);

        // Write 0x2A+W, data 0xAB
        am0 = n_am; rv0 = n_rxv;
        start_cond();
        write_byte(8'h54, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy_after_match", {31'd0, busy}, 32'd1);
        q_rx.push_back(8'hAB);
        write_byte(8'hAB, ack);
        check("wr_data_ack", {31'd0, ack}, 32'd0);
        check("wr_busy_before_stop", {31'd0, busy}, 32'd1);
        stop_cond();
        wclk(5);
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_addr_match_cnt", n_am - am0, 32'd1);
        check("wr_rx_valid_cnt", n_rxv - rv0, 32'd1);
        check("wr_rx_queue_empty", q_rx.size(), 32'd0);

        // Wrong address 0x2B+W
        am0 = n_am; rv0 = n_rxv; tl0 = n_tgt_low;
        start_cond();
        write_byte(8'h56, ack);
        check("bad_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'hAB, ack);
        check("bad_data_nack", {31'd0, ack}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        stop_cond();
        wclk(5);
        check("bad_tgt_low_cycles", n_tgt_low - tl0, 32'd0);
        check("bad_addr_match_cnt", n_am - am0, 32'd0);
        check("bad_rx_valid_cnt", n_rxv - rv0, 32'd0);

        // Single-byte read of 0x5C, master NACK
        tx_data = 8'h5C; tx0 = n_txl;
        start_cond();
        write_byte(8'h55, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b0, obs);
        check("rd_byte", {24'd0, d}, 32'h5C);
        check("rd_ack_slot_released", {31'd0, obs}, 32'd1);
        check("rd_state_wait_stop", {29'd0, dut.r_state}, {29'd0, WAIT_STOP});
        check("rd_tx_load_cnt", n_txl - tx0, 32'd1);
        stop_cond();
        wclk(5);
        check("rd_state_idle", {29'd0, dut.r_state}, {29'd0, IDLE});

        // Two-byte read: 0xA5 (ACK) then 0x3C (NACK)
        tx_data = 8'hA5; tx0 = n_txl;
        start_cond();
        write_byte(8'h55, ack);
        wclk(8);
        check("rd2_first_load", n_txl - tx0, 32'd1);
        tx_data = 8'h3C;
        read_byte(d, 1'b1, obs);
        check("rd2_byte0", {24'd0, d}, 32'hA5);
        read_byte(d, 1'b0, obs);
        check("rd2_byte1", {24'd0, d}, 32'h3C);
        stop_cond();
        wclk(5);
        check("rd2_tx_load_cnt", n_txl - tx0, 32'd2);

        // Repeated START after 3 data bits, then read 0x96
        rv0 = n_rxv; tx_data = 8'h96;
        start_cond();
        write_byte(8'h54, ack);
        write_bits(8'hA0, 3);
        start_cond();
        check("rs_busy_held", {31'd0, busy}, 32'd1);
        write_byte(8'h55, ack);
        check("rs_read_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b0, obs);
        check("rs_read_byte", {24'd0, d}, 32'h96);
        stop_cond();
        wclk(5);
        check("rs_rx_valid_cnt", n_rxv - rv0, 32'd0);

        // STOP after 5 data bits
        rv0 = n_rxv;
        start_cond();
        write_byte(8'h54, ack);
        write_bits(8'hF8, 5);
        stop_cond();
        wclk(5);
        check("stop5_rx_valid_cnt", n_rxv - rv0, 32'd0);
        check("stop5_busy", {31'd0, busy}, 32'd0);
        check("stop5_state_idle", {29'd0, dut.r_state}, {29'd0, IDLE});
        check("stop5_sda_released", {31'd0, sda_bus}, 32'd1);

        // Reset while the target holds the address ACK low
        start_cond();
        write_bits(8'h54, 8);
        wclk(Q); m_sda_low = 1'b0;
        wclk(Q); m_scl = 1'b1;
        wclk(Q);
        check("rst_mid_ack_low", {31'd0, sda_bus}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_sda_released", {31'd0, sda_bus}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_mid_outputs", {29'd0, addr_match, rx_valid, tx_load}, 32'd0);
        check("rst_mid_state", {29'd0, dut.r_state}, {29'd0, IDLE});
        tl0 = n_tgt_low;
        wclk(2); rst = 1'b0;
        wclk(Q); m_scl = 1'b0;
        stop_cond();
        check("rst_no_glitch", n_tgt_low - tl0, 32'd0);
        am0 = n_am;
        start_cond();
        write_byte(8'h54, ack);
        check("post_rst_addr_ack", {31'd0, ack}, 32'd0);
        stop_cond();
        wclk(5);
        check("post_rst_addr_match_cnt", n_am - am0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
